// File: rtl/apb_to_obi_ss_if.sv
// Signal bundle for the APB-to-OBI bridge: APB completer side plus OBI initiator side.
// slave = bridge view; master = view of the surrounding APB master and OBI target.
interface apb_to_obi_ss_if #(
    parameter int APB_AW  = 32,
    parameter int APB_DW  = 32,
    parameter int OBI_AW  = 32,
    parameter int OBI_DW  = 32,
    parameter int OBI_IDW = 1
);
    logic [APB_AW-1:0]   APB_PADDR;
    logic                APB_PSEL;
    logic                APB_PENABLE;
    logic                APB_PWRITE;
    logic [APB_DW-1:0]   APB_PWDATA;
    logic [APB_DW/8-1:0] APB_PSTRB;
    logic                APB_PREADY;
    logic [APB_DW-1:0]   APB_PRDATA;
    logic                APB_PSLVERR;

    logic                obi_req;
    logic                obi_gnt;
    logic [OBI_AW-1:0]   obi_addr;
    logic                obi_we;
    logic [OBI_DW/8-1:0] obi_be;
    logic [OBI_DW-1:0]   obi_wdata;
    logic [OBI_IDW-1:0]  obi_aid;
    logic                obi_rvalid;
    logic                obi_rready;
    logic [OBI_DW-1:0]   obi_rdata;
    logic                obi_err;
    logic [OBI_IDW-1:0]  obi_rid;
    logic                obi_reqpar;
    logic                obi_gntpar;
    logic                obi_rvalidpar;
    logic                obi_rreadypar;

    modport slave (
        input  APB_PADDR, APB_PSEL, APB_PENABLE, APB_PWRITE, APB_PWDATA, APB_PSTRB,
        output APB_PREADY, APB_PRDATA, APB_PSLVERR,
        output obi_req, obi_addr, obi_we, obi_be, obi_wdata, obi_aid, obi_rready,
        output obi_reqpar, obi_rreadypar,
        input  obi_gnt, obi_rvalid, obi_rdata, obi_err, obi_rid, obi_gntpar, obi_rvalidpar
    );

    modport master (
        output APB_PADDR, APB_PSEL, APB_PENABLE, APB_PWRITE, APB_PWDATA, APB_PSTRB,
        input  APB_PREADY, APB_PRDATA, APB_PSLVERR,
        input  obi_req, obi_addr, obi_we, obi_be, obi_wdata, obi_aid, obi_rready,
        input  obi_reqpar, obi_rreadypar,
        output obi_gnt, obi_rvalid, obi_rdata, obi_err, obi_rid, obi_gntpar, obi_rvalidpar
    );
endinterface

// File: rtl/apb_to_obi_ss.sv
// APB completer to OBI initiator bridge, one outstanding transfer per APB access.
// Optional OBI handshake parity checking/generation: define APB_TO_OBI_PARITY_EN.
module apb_to_obi_ss #(
    parameter int                 APB_AW      = 32,
    parameter int                 APB_DW      = 32,
    parameter int                 OBI_AW      = 32,
    parameter int                 OBI_DW      = 32,
    parameter int                 OBI_IDW     = 1,
    parameter logic [OBI_IDW-1:0] OBI_AID     = '0,
    parameter logic [31:0]        ADDR_OFFSET = 32'h0105_0000
) (
    input  logic           clk,
    input  logic           reset,
    apb_to_obi_ss_if.slave bus,
    output logic [1:0]     o_dbg_state
);
    // Handshakes: OBI address phase completes on req & gnt, OBI response on rvalid & rready;
    // the APB transfer completes in the single cycle PREADY is high while PSEL & PENABLE.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RSP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_abort;
    logic                w_abort;
    logic                w_rsp_hs;
    logic                w_rsp_ok;
    logic                w_par_flag;
    logic                r_req;
    logic                r_rready;
    logic                r_we;
    logic [OBI_AW-1:0]   r_addr;
    logic [OBI_DW/8-1:0] r_be;
    logic [OBI_DW-1:0]   r_wdata;
    logic                r_pready;
    logic [APB_DW-1:0]   r_prdata;
    logic                r_pslverr;

    // An APB master that let go of PSEL mid-transfer no longer wants the result.
    assign w_abort  = r_abort || !bus.APB_PSEL;
    assign w_rsp_hs = (r_state == S_RSP) && bus.obi_rvalid;
    assign w_rsp_ok = w_rsp_hs && !w_abort;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.APB_PSEL) w_state_nxt = S_REQ;
            S_REQ:   if (bus.obi_gnt) w_state_nxt = S_RSP;
            S_RSP:   if (bus.obi_rvalid) w_state_nxt = w_abort ? S_IDLE : S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_abort   <= 1'b0;
            r_req     <= 1'b0;
            r_rready  <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_be      <= '0;
            r_wdata   <= '0;
            r_pready  <= 1'b0;
            r_prdata  <= '0;
            r_pslverr <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_req     <= (w_state_nxt == S_REQ);
            r_rready  <= (w_state_nxt == S_RSP);
            r_pready  <= w_rsp_ok;
            r_pslverr <= w_rsp_ok && (bus.obi_err || w_par_flag);
            r_prdata  <= (w_rsp_ok && !r_we) ? bus.obi_rdata : '0;
            // Payload is captured once at the start; APB inputs are ignored afterwards.
            if ((r_state == S_IDLE) && bus.APB_PSEL) begin
                r_abort <= 1'b0;
                r_we    <= bus.APB_PWRITE;
                r_addr  <= OBI_AW'(ADDR_OFFSET) + OBI_AW'(bus.APB_PADDR);
                r_be    <= bus.APB_PWRITE ? bus.APB_PSTRB : '1;
                r_wdata <= bus.APB_PWDATA;
            end else if (((r_state == S_REQ) || (r_state == S_RSP)) && !bus.APB_PSEL) begin
                r_abort <= 1'b1;
            end
        end
    end

`ifdef APB_TO_OBI_PARITY_EN
    logic r_par_err;
    logic r_reqpar;
    logic r_rreadypar;
    logic w_par_bad;
    logic w_unused;

    // Parity lines are complements; equality with the data line means corruption.
    assign w_par_bad  = ((r_state == S_REQ) && (bus.obi_gntpar == bus.obi_gnt)) ||
                        ((r_state == S_RSP) && (bus.obi_rvalidpar == bus.obi_rvalid));
    assign w_par_flag = r_par_err || w_par_bad;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_par_err   <= 1'b0;
            r_reqpar    <= 1'b1;
            r_rreadypar <= 1'b1;
        end else begin
            r_reqpar    <= (w_state_nxt != S_REQ);
            r_rreadypar <= (w_state_nxt != S_RSP);
            if (w_rsp_hs || (r_state == S_IDLE)) begin
                r_par_err <= 1'b0;
            end else if (w_par_bad) begin
                r_par_err <= 1'b1;
            end
        end
    end

    assign bus.obi_reqpar    = r_reqpar;
    assign bus.obi_rreadypar = r_rreadypar;
    assign w_unused          = ^{bus.obi_rid, bus.APB_PENABLE};
`else
    logic w_unused;

    assign w_par_flag        = 1'b0;
    assign bus.obi_reqpar    = 1'b1;
    assign bus.obi_rreadypar = 1'b1;
    assign w_unused          = ^{bus.obi_rid, bus.APB_PENABLE, bus.obi_gntpar, bus.obi_rvalidpar};
`endif

    assign bus.APB_PREADY  = r_pready;
    assign bus.APB_PRDATA  = r_prdata;
    assign bus.APB_PSLVERR = r_pslverr;
    assign bus.obi_req     = r_req;
    assign bus.obi_addr    = r_addr;
    assign bus.obi_we      = r_we;
    assign bus.obi_be      = r_be;
    assign bus.obi_wdata   = r_wdata;
    assign bus.obi_aid     = OBI_AID;
    assign bus.obi_rready  = r_rready;
    assign o_dbg_state     = r_state;
endmodule
